// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU issue/sequencing logic: opcode encodings,
// default execute latencies and the sequencer state enum. Also used by the
// hazard unit through fpu_op_decode.
// -----------------------------------------------------------------------------
package fpu_pkg;

    // Opcode encodings on ReqOp / FPUCtrl; 8..15 are illegal.
    localparam logic [3:0] OP_ADD32 = 4'd0;
    localparam logic [3:0] OP_SUB32 = 4'd1;
    localparam logic [3:0] OP_MUL32 = 4'd2;
    localparam logic [3:0] OP_DIV32 = 4'd3;
    localparam logic [3:0] OP_ADD64 = 4'd4;
    localparam logic [3:0] OP_SUB64 = 4'd5;
    localparam logic [3:0] OP_MUL64 = 4'd6;
    localparam logic [3:0] OP_DIV64 = 4'd7;

    // Default execute latencies in cycles (legal range 1..32).
    localparam int unsigned DEF_LAT_ADD   = 2;
    localparam int unsigned DEF_LAT_MUL   = 4;
    localparam int unsigned DEF_LAT_DIV32 = 12;
    localparam int unsigned DEF_LAT_DIV64 = 24;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

endpackage

// File: rtl/fpu_op_decode.sv
// -----------------------------------------------------------------------------
// fpu_op_decode
// Combinational opcode decoder: reports whether an opcode is legal and its
// execute latency. Latency is returned minus one so the full 1..32 range fits
// in five bits; it is the value the sequencer loads into its down-counter.
//
// Ports:
//   op_i      in  [3:0]  opcode
//   legal_o   out        opcode is one of ADD32..DIV64
//   lat_m1_o  out [4:0]  execute latency - 1 (0 for illegal opcodes)
// -----------------------------------------------------------------------------
module fpu_op_decode
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD   = DEF_LAT_ADD,
    parameter int unsigned LAT_MUL   = DEF_LAT_MUL,
    parameter int unsigned LAT_DIV32 = DEF_LAT_DIV32,
    parameter int unsigned LAT_DIV64 = DEF_LAT_DIV64
) (
    input  logic [3:0] op_i,
    output logic       legal_o,
    output logic [4:0] lat_m1_o
);

    localparam logic [4:0] ADD_M1   = 5'(LAT_ADD - 1);
    localparam logic [4:0] MUL_M1   = 5'(LAT_MUL - 1);
    localparam logic [4:0] DIV32_M1 = 5'(LAT_DIV32 - 1);
    localparam logic [4:0] DIV64_M1 = 5'(LAT_DIV64 - 1);

    always_comb begin
        legal_o  = 1'b1;
        lat_m1_o = '0;
        case (op_i)
            OP_ADD32, OP_SUB32, OP_ADD64, OP_SUB64: lat_m1_o = ADD_M1;
            OP_MUL32, OP_MUL64:                     lat_m1_o = MUL_M1;
            OP_DIV32:                               lat_m1_o = DIV32_M1;
            OP_DIV64:                               lat_m1_o = DIV64_M1;
            default:                                legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_sequencer
// Issue/sequencing controller for the FPU datapath. Accepts one operation at a
// time, drives the registered opcode/operands onto the FPU for an
// opcode-dependent number of cycles, captures the FPU result and presents it
// with its destination register until the consumer takes it.
//
// Ports:
//   Clk, Reset_n          clock; asynchronous active-low reset
//   ReqValid/ReqReady     request handshake (ReqReady is combinational)
//   ReqOp, ReqDest        opcode and destination register of the request
//   ReqA, ReqB            operands (32-bit ops use bits [31:0])
//   Flush                 abort any in-flight or pending operation
//   FPUCtrl, FPUBusA/B    registered opcode/operands to the FPU
//   FPUBusO               FPU result
//   RespValid/RespReady   response handshake
//   RespData, RespDest    captured result and its destination register
//   Busy                  sequencer is not idle
//   IllegalOp             one-cycle pulse after an illegal opcode was dropped
// -----------------------------------------------------------------------------
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD   = DEF_LAT_ADD,
    parameter int unsigned LAT_MUL   = DEF_LAT_MUL,
    parameter int unsigned LAT_DIV32 = DEF_LAT_DIV32,
    parameter int unsigned LAT_DIV64 = DEF_LAT_DIV64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [3:0]  ReqOp,
    input  logic [4:0]  ReqDest,
    input  logic [63:0] ReqA,
    input  logic [63:0] ReqB,
    input  logic        Flush,
    output logic [3:0]  FPUCtrl,
    output logic [63:0] FPUBusA,
    output logic [63:0] FPUBusB,
    input  logic [63:0] FPUBusO,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [63:0] RespData,
    output logic [4:0]  RespDest,
    output logic        Busy,
    output logic        IllegalOp
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [63:0] busa_q, busa_d;
    logic [63:0] busb_q, busb_d;
    logic [4:0]  dest_q, dest_d;
    logic [63:0] rdata_q, rdata_d;
    logic [4:0]  rdest_q, rdest_d;
    logic        illegal_q, illegal_d;

    logic        op_legal;
    logic [4:0]  op_lat_m1;
    logic        accept;
    logic        load;

    fpu_op_decode #(
        .LAT_ADD   (LAT_ADD),
        .LAT_MUL   (LAT_MUL),
        .LAT_DIV32 (LAT_DIV32),
        .LAT_DIV64 (LAT_DIV64)
    ) u_decode (
        .op_i     (ReqOp),
        .legal_o  (op_legal),
        .lat_m1_o (op_lat_m1)
    );

    // Ready in DONE only when the pending result drains this same cycle,
    // which gives back-to-back issue.
    assign ReqReady = !Flush && ((state_q == IDLE) || ((state_q == DONE) && RespReady));
    assign accept   = ReqValid && ReqReady;
    assign load     = accept && op_legal;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        busa_d    = busa_q;
        busb_d    = busb_q;
        dest_d    = dest_q;
        rdata_d   = rdata_q;
        rdest_d   = rdest_q;
        illegal_d = accept && !op_legal;

        // Accept is already blocked by Flush, so a load never competes with it.
        if (Flush) begin
            state_d = IDLE;
        end else if (load) begin
            ctrl_d  = ReqOp;
            busa_d  = ReqA;
            busb_d  = ReqB;
            dest_d  = ReqDest;
            cnt_d   = op_lat_m1;
            state_d = EXEC;
        end else begin
            case (state_q)
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        rdata_d = FPUBusO;
                        rdest_d = dest_q;
                        state_d = DONE;
                    end
                end
                // An illegal accept in DONE also consumes the result.
                DONE:    if (RespReady) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            busa_q    <= '0;
            busb_q    <= '0;
            dest_q    <= '0;
            rdata_q   <= '0;
            rdest_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            busa_q    <= busa_d;
            busb_q    <= busb_d;
            dest_q    <= dest_d;
            rdata_q   <= rdata_d;
            rdest_q   <= rdest_d;
            illegal_q <= illegal_d;
        end
    end

    assign FPUCtrl   = ctrl_q;
    assign FPUBusA   = busa_q;
    assign FPUBusB   = busb_q;
    assign RespData  = rdata_q;
    assign RespDest  = rdest_q;
    assign RespValid = (state_q == DONE);
    assign Busy      = (state_q != IDLE);
    assign IllegalOp = illegal_q;

endmodule

// File: doc/fpu_sequencer.md
# fpu_sequencer

Multi-cycle issue/sequencing controller for the FPU datapath. It accepts one floating-point operation at a time from the pipeline over a valid/ready handshake and registers the operands and opcode onto the FPU's BusA/BusB/FPUCtrl inputs. It holds them stable for an opcode-dependent number of cycles, then captures BusO and presents the result with its destination register over a second valid/ready handshake. The pipeline uses Busy to stall dependent FP instructions.

## Interface
- LAT_ADD, 2: execute cycles for ADD32/SUB32/ADD64/SUB64 (legal range 1..32)
- LAT_MUL, 4: execute cycles for MUL32/MUL64
- LAT_DIV32, 12: execute cycles for DIV32
- LAT_DIV64, 24: execute cycles for DIV64

- Clk  in  1  clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReqValid  in  1  operation request valid
- ReqReady  out  1  sequencer can accept a request this cycle
- ReqOp  in  4  opcode: 0 ADD32, 1 SUB32, 2 MUL32, 3 DIV32, 4 ADD64, 5 SUB64, 6 MUL64, 7 DIV64; 8..15 illegal
- ReqDest  in  5  destination FP register index
- ReqA, ReqB  in  64  operands (32-bit ops use bits [31:0])
- Flush  in  1  abort any in-flight or pending operation
- FPUCtrl  out  4  registered opcode to the FPU
- FPUBusA, FPUBusB  out  64  registered operands to the FPU
- FPUBusO  in  64  FPU result
- RespValid  out  1  result available
- RespReady  in  1  consumer accepts result
- RespData  out  64  captured result
- RespDest  out  5  destination of RespData
- Busy  out  1  state is not IDLE
- IllegalOp  out  1  one-cycle pulse: illegal opcode was accepted and dropped

## Operation
- States: IDLE, EXEC, DONE. Reset puts the block in IDLE.
- ReqReady = !Flush && (IDLE || (DONE && RespReady)). The signal is combinational and allows back-to-back issue while a result drains.
- Accept = ReqValid && ReqReady.
  - Legal opcode: latch ReqOp, ReqA, ReqB and ReqDest into FPUCtrl, FPUBusA, FPUBusB and the internal dest register. Load the 5-bit counter with LAT(op)-1. Go to EXEC.
  - Illegal opcode: pulse IllegalOp on the next cycle. Registers are not updated. Go to or stay in IDLE; no response is produced.
- EXEC: when the counter is nonzero, decrement it. When it is 0, capture FPUBusO into RespData and dest into RespDest, then go to DONE.
- DONE: RespValid = 1. RespData and RespDest stay stable until the handshake completes.
  - RespReady with no new accept: go to IDLE.
  - RespReady with a legal accept in the same cycle: go to EXEC for the new op.
- Flush (highest priority): from any state, go to IDLE next edge and clear RespValid. The in-flight result is discarded and no accept occurs that cycle. FPUBus*/FPUCtrl keep their last values.
- ReqOp, ReqA and ReqB are ignored when no accept occurs.

## Timing
- Reset values:
  - 0: FPUCtrl, FPUBusA, FPUBusB, RespData, RespDest, RespValid, Busy, IllegalOp.
  - 1: ReqReady (with Flush low).
- Latency: accept at edge N, RespValid high in the cycle after edge N+LAT(op). EXEC occupies exactly LAT(op) cycles.
- Throughput: one op per LAT(op)+1 cycles when RespReady is held high.
- Busy is registered from the state and rises the cycle after accept.
- Reset_n asserted mid-EXEC or mid-DONE forces reset values immediately, without waiting for a clock edge.

## Structure
- Shared package fpu_pkg holds:
  - opcode constants ADD32..DIV64;
  - default latency localparams;
  - the state enum {IDLE, EXEC, DONE}.
- Sub-module fpu_op_decode (combinational) maps the 4-bit opcode to {legal, latency[4:0]}. It is reusable by the hazard unit.
- All remaining logic is one module: the state register, counter, operand/result registers and handshake logic.

## Test plan
- Single op: ADD32 with A=0x3F800000, B=0x40000000, Dest=3, and a stub FPU returning 0x40400000. Required response: RespValid exactly 2 cycles after accept, RespData=0x40400000, RespDest=3.
- Latency sweep: issue each of the 8 opcodes. Required response: accept-to-RespValid distance is 2/2/4/12/2/2/4/24 cycles, and FPUCtrl equals the opcode throughout EXEC.
- Backpressure/back-to-back:
  - Hold RespReady=0 for 5 cycles after a MUL64 result. Required response: RespData stable, ReqReady=0.
  - Then raise RespReady together with ReqValid for DIV32. Required response: the new op is accepted in that same cycle.
- Illegal opcode: ReqOp=4'b1010. Required response: IllegalOp pulses for 1 cycle, Busy stays 0, no RespValid.
- Flush:
  - Flush in EXEC cycle 7 of DIV64. Required response: IDLE next cycle, RespValid never rises.
  - Flush in DONE with RespReady=0. Required response: RespValid drops the next cycle.
  - Flush with ReqValid high. Required response: no accept.
- Async reset: assert Reset_n=0 mid-DIV64 between clock edges. Required response: all outputs take their reset values immediately; after release, ReqReady=1.
